// File: rtl/tpu_uart_pkg.sv
// Shared definitions for the UART command controller.
// Opcodes, controller states, response framing constants, and a helper
// that packs the MLP status pair into the response byte layout.
package tpu_uart_pkg;

  typedef enum logic [7:0] {
    OP_LOAD_W0     = 8'h01,
    OP_LOAD_W1     = 8'h02,
    OP_LOAD_ACT    = 8'h03,
    OP_WF_RESET    = 8'h04,
    OP_SET_READY   = 8'h05,
    OP_START       = 8'h06,
    OP_READ_STATUS = 8'h07,
    OP_READ_ACC    = 8'h08
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG_W,
    ST_ARG_ACT_LO,
    ST_ARG_ACT_HI,
    ST_TX_RESP
  } state_e;

  localparam logic [7:0] NAK_BYTE       = 8'hEE;
  localparam int         RESP_MAX_BYTES = 8;
  localparam int         RESP_BITS      = 8 * RESP_MAX_BYTES;
  localparam int         RESP_CNT_W     = $clog2(RESP_MAX_BYTES + 1);

  localparam logic [RESP_CNT_W-1:0] LEN_NAK    = RESP_CNT_W'(1);
  localparam logic [RESP_CNT_W-1:0] LEN_STATUS = RESP_CNT_W'(2);
  localparam logic [RESP_CNT_W-1:0] LEN_ACC    = RESP_CNT_W'(8);

  // Byte 0 = state, byte 1 = cycle count; remaining bytes unused.
  function automatic logic [RESP_BITS-1:0] pack_status(input logic [3:0] st,
                                                       input logic [4:0] cnt);
    return {48'h0, 3'h0, cnt, 4'h0, st};
  endfunction

endpackage

// File: rtl/uart_resp_ser.sv
// Response serialiser: holds up to RESP_MAX_BYTES bytes and presents them
// one at a time on a valid/ready byte interface, byte 0 first.
// Ports:
//   load/load_len/load_data : capture a new response (only loaded when idle)
//   tx_valid/tx_data/tx_ready : byte handshake toward UART TX
//   done : high in the cycle whose handshake consumes the final byte
// The buffer shifts down on every handshake so tx_data comes straight from
// a flop and stays stable while the consumer stalls.
module uart_resp_ser
  import tpu_uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [RESP_CNT_W-1:0] load_len,
  input  logic [RESP_BITS-1:0]  load_data,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic                  done
);

  logic [RESP_MAX_BYTES-1:0][7:0] data_q, data_d;
  logic [RESP_CNT_W-1:0]          rem_q, rem_d;
  logic                           valid_q, valid_d;
  logic                           hs;

  always_comb begin
    data_d  = data_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    hs      = valid_q && tx_ready;
    done    = hs && (rem_q == RESP_CNT_W'(1));
    if (load) begin
      data_d  = load_data;
      rem_d   = load_len;
      valid_d = (load_len != '0);
    end else if (hs) begin
      data_d  = {8'h00, data_q[RESP_MAX_BYTES-1:1]};
      rem_d   = rem_q - RESP_CNT_W'(1);
      valid_d = !done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

  assign tx_valid = valid_q;
  assign tx_data  = data_q[0];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Byte-level command decoder between UART RX/TX and the TPU bridge
// controller ports. Parses opcode + argument bytes into registered one-cycle
// strobes / levels for the weight FIFO, activation load, MLP start and
// weights-ready, and returns status / accumulator snapshots over UART TX.
// Ports:
//   rx_valid/rx_data           : incoming bytes (one-cycle strobe)
//   tx_valid/tx_data/tx_ready  : outgoing response bytes
//   ctrl_*                     : bridge control outputs (all registered)
//   mlp_*                      : MLP status, snapshotted on READ_* accept
//   cmd_err                    : one-cycle error strobe
module uart_cmd_ctrl
  import tpu_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               ctrl_wf_push_col0,
  output logic               ctrl_wf_push_col1,
  output logic [7:0]         ctrl_wf_data_in,
  output logic               ctrl_wf_reset,
  output logic               ctrl_init_act_valid,
  output logic [15:0]        ctrl_init_act_data,
  output logic               ctrl_start_mlp,
  output logic               ctrl_weights_ready,
  input  logic [3:0]         mlp_state,
  input  logic [4:0]         mlp_cycle_cnt,
  input  logic signed [31:0] mlp_acc0,
  input  logic signed [31:0] mlp_acc1,
  output logic               cmd_err
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic            col_q, col_d;
  logic [7:0]      act_lo_q, act_lo_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            push0_q, push0_d;
  logic            push1_q, push1_d;
  logic [7:0]      wf_data_q, wf_data_d;
  logic            wf_rst_q, wf_rst_d;
  logic            act_vld_q, act_vld_d;
  logic [15:0]     act_data_q, act_data_d;
  logic            start_q, start_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;

  logic                  ser_load;
  logic [RESP_CNT_W-1:0] ser_len;
  logic [RESP_BITS-1:0]  ser_data;
  logic                  ser_done;
  logic                  in_arg;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    act_lo_d   = act_lo_q;
    tmo_d      = '0;
    push0_d    = 1'b0;
    push1_d    = 1'b0;
    wf_data_d  = wf_data_q;
    wf_rst_d   = 1'b0;
    act_vld_d  = 1'b0;
    act_data_d = act_data_q;
    start_d    = 1'b0;
    ready_d    = ready_q;
    err_d      = 1'b0;
    ser_load   = 1'b0;
    ser_len    = '0;
    ser_data   = '0;
    in_arg     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (opcode_e'(rx_data))
            OP_LOAD_W0: begin
              col_d   = 1'b0;
              state_d = ST_ARG_W;
            end
            OP_LOAD_W1: begin
              col_d   = 1'b1;
              state_d = ST_ARG_W;
            end
            OP_LOAD_ACT:  state_d = ST_ARG_ACT_LO;
            OP_WF_RESET: begin
              wf_rst_d = 1'b1;
              ready_d  = 1'b0;
            end
            OP_SET_READY: ready_d = 1'b1;
            OP_START: begin
              // Starting without weights is refused rather than forwarded.
              if (ready_q) start_d = 1'b1;
              else         err_d   = 1'b1;
            end
            OP_READ_STATUS: begin
              ser_load = 1'b1;
              ser_len  = LEN_STATUS;
              ser_data = pack_status(mlp_state, mlp_cycle_cnt);
              state_d  = ST_TX_RESP;
            end
            OP_READ_ACC: begin
              ser_load = 1'b1;
              ser_len  = LEN_ACC;
              ser_data = {mlp_acc1, mlp_acc0};
              state_d  = ST_TX_RESP;
            end
            default: begin
              err_d    = 1'b1;
              ser_load = 1'b1;
              ser_len  = LEN_NAK;
              ser_data = {{(RESP_BITS-8){1'b0}}, NAK_BYTE};
              state_d  = ST_TX_RESP;
            end
          endcase
        end
      end
      ST_ARG_W: begin
        in_arg = 1'b1;
        if (rx_valid) begin
          wf_data_d = rx_data;
          push0_d   = !col_q;
          push1_d   = col_q;
          state_d   = ST_IDLE;
        end
      end
      ST_ARG_ACT_LO: begin
        in_arg = 1'b1;
        if (rx_valid) begin
          act_lo_d = rx_data;
          state_d  = ST_ARG_ACT_HI;
        end
      end
      ST_ARG_ACT_HI: begin
        in_arg = 1'b1;
        if (rx_valid) begin
          act_vld_d  = 1'b1;
          act_data_d = {rx_data, act_lo_q};
          state_d    = ST_IDLE;
        end
      end
      ST_TX_RESP: begin
        // Bytes arriving mid-response are dropped and flagged; the
        // serialiser keeps going untouched.
        if (rx_valid) err_d = 1'b1;
        if (ser_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle-cycle counter for argument states. A byte in the final allowed
    // cycle still wins over the abort.
    if (in_arg && !rx_valid) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      col_q      <= 1'b0;
      act_lo_q   <= '0;
      tmo_q      <= '0;
      push0_q    <= 1'b0;
      push1_q    <= 1'b0;
      wf_data_q  <= '0;
      wf_rst_q   <= 1'b0;
      act_vld_q  <= 1'b0;
      act_data_q <= '0;
      start_q    <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      act_lo_q   <= act_lo_d;
      tmo_q      <= tmo_d;
      push0_q    <= push0_d;
      push1_q    <= push1_d;
      wf_data_q  <= wf_data_d;
      wf_rst_q   <= wf_rst_d;
      act_vld_q  <= act_vld_d;
      act_data_q <= act_data_d;
      start_q    <= start_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  uart_resp_ser u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_len  (ser_len),
    .load_data (ser_data),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .done      (ser_done)
  );

  assign ctrl_wf_push_col0   = push0_q;
  assign ctrl_wf_push_col1   = push1_q;
  assign ctrl_wf_data_in     = wf_data_q;
  assign ctrl_wf_reset       = wf_rst_q;
  assign ctrl_init_act_valid = act_vld_q;
  assign ctrl_init_act_data  = act_data_q;
  assign ctrl_start_mlp      = start_q;
  assign ctrl_weights_ready  = ready_q;
  assign cmd_err             = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b0;
  logic              push0, push1, wf_reset, act_valid, start_mlp, wready, cmd_err;
  logic [7:0]        wf_data;
  logic [15:0]       act_data;
  logic [3:0]        mlp_state = 4'h0;
  logic [4:0]        mlp_cycle_cnt = 5'h0;
  logic signed [31:0] mlp_acc0 = 32'sh0, mlp_acc1 = 32'sh0;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ctrl_wf_push_col0(push0), .ctrl_wf_push_col1(push1),
    .ctrl_wf_data_in(wf_data), .ctrl_wf_reset(wf_reset),
    .ctrl_init_act_valid(act_valid), .ctrl_init_act_data(act_data),
    .ctrl_start_mlp(start_mlp), .ctrl_weights_ready(wready),
    .mlp_state(mlp_state), .mlp_cycle_cnt(mlp_cycle_cnt),
    .mlp_acc0(mlp_acc0), .mlp_acc1(mlp_acc1),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int push0, push1, act, wfrst, start, err, ntx;
    logic [63:0] tx;
  } exp_t;

  typedef struct {
    logic [7:0]  op, a1, a2;
    int          nb;
    exp_t        e;
    logic        ready;
    logic [7:0]  wf;
    logic [15:0] act;
  } vec_t;

  int vecs = 0, miscompares = 0;
  int n_push0, n_push1, n_act, n_wfrst, n_start, n_err;
  logic [7:0] txq[$];
  logic rdy_rand = 1'b0, rdy_fixed = 1'b1;
  logic hold_q = 1'b0;
  logic [7:0] hold_data = 8'h00;

  // reference model state
  logic        m_ready = 1'b0;
  logic [7:0]  m_wf = 8'h00;
  logic [15:0] m_act = 16'h0000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (push0)     n_push0++;
    if (push1)     n_push1++;
    if (act_valid) n_act++;
    if (wf_reset)  n_wfrst++;
    if (start_mlp) n_start++;
    if (cmd_err)   n_err++;
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (hold_q && tx_valid) check("tx_data_stable", 64'(tx_data), 64'(hold_data));
    hold_q    = tx_valid && !tx_ready;
    hold_data = tx_data;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      tx_ready = rdy_rand ? 1'($urandom) : rdy_fixed;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic clear_cap;
    n_push0 = 0; n_push1 = 0; n_act = 0; n_wfrst = 0; n_start = 0; n_err = 0;
    txq.delete();
  endtask

  task automatic wait_quiet;
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (!tx_valid) done = 1;
    end
    if (!done) check("tx_drain_timeout", 64'(tx_valid), 64'd0);
    @(posedge clk); #1;
    idle(2);
  endtask

  function automatic exp_t mkexp(int p0, int p1, int ac, int wr, int st, int er,
                                 int ntx, logic [63:0] tx);
    exp_t e;
    e.push0 = p0; e.push1 = p1; e.act = ac; e.wfrst = wr; e.start = st;
    e.err = er; e.ntx = ntx; e.tx = tx;
    return e;
  endfunction

  function automatic vec_t mkvec(logic [7:0] op, logic [7:0] a1, logic [7:0] a2, int nb,
                                 exp_t e, logic rdy, logic [7:0] wf, logic [15:0] act);
    vec_t v;
    v.op = op; v.a1 = a1; v.a2 = a2; v.nb = nb; v.e = e;
    v.ready = rdy; v.wf = wf; v.act = act;
    return v;
  endfunction

  task automatic check_cmd(input string tag, input exp_t e, input logic rdy,
                           input logic [7:0] wf, input logic [15:0] act);
    check({tag, ".push0"}, 64'(n_push0), 64'(e.push0));
    check({tag, ".push1"}, 64'(n_push1), 64'(e.push1));
    check({tag, ".act_valid"}, 64'(n_act), 64'(e.act));
    check({tag, ".wf_reset"}, 64'(n_wfrst), 64'(e.wfrst));
    check({tag, ".start"}, 64'(n_start), 64'(e.start));
    check({tag, ".cmd_err"}, 64'(n_err), 64'(e.err));
    check({tag, ".weights_ready"}, 64'(wready), 64'(rdy));
    check({tag, ".wf_data"}, 64'(wf_data), 64'(wf));
    check({tag, ".act_data"}, 64'(act_data), 64'(act));
    check({tag, ".tx_len"}, 64'(txq.size()), 64'(e.ntx));
    for (int i = 0; i < e.ntx && i < txq.size(); i++)
      check($sformatf("%s.tx[%0d]", tag, i), 64'(txq[i]), 64'(e.tx[8*i +: 8]));
  endtask

  task automatic send_cmd(input logic [7:0] op, a1, a2, input int nb, input int gap);
    send_byte(op);
    if (nb > 1) begin idle(gap); send_byte(a1); end
    if (nb > 2) begin idle(gap); send_byte(a2); end
  endtask

  // Behavioural model: what one complete command should produce.
  task automatic model_cmd(input logic [7:0] op, a1, a2, output exp_t e, output int nb);
    e = mkexp(0, 0, 0, 0, 0, 0, 0, 64'h0);
    nb = 1;
    case (op)
      8'h01: begin e.push0 = 1; m_wf = a1; nb = 2; end
      8'h02: begin e.push1 = 1; m_wf = a1; nb = 2; end
      8'h03: begin e.act = 1; m_act = {a2, a1}; nb = 3; end
      8'h04: begin e.wfrst = 1; m_ready = 1'b0; end
      8'h05: m_ready = 1'b1;
      8'h06: if (m_ready) e.start = 1; else e.err = 1;
      8'h07: begin
        e.ntx = 2;
        e.tx = 64'(mlp_state) | (64'(mlp_cycle_cnt) << 8);
      end
      8'h08: begin
        e.ntx = 8;
        e.tx = {32'(mlp_acc1), 32'(mlp_acc0)};
      end
      default: begin e.err = 1; e.ntx = 1; e.tx = 64'hEE; end
    endcase
  endtask

  vec_t tab[$];

  initial begin
    exp_t e;
    int nb;
    logic [7:0] op, a1, a2;

    // reset state
    @(posedge clk); #1;
    check("reset_outputs", {tx_valid, push0, push1, wf_data, wf_reset, act_valid,
                            act_data, start_mlp, wready, cmd_err}, 64'h0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // ---- table-driven vectors ----
    mlp_state = 4'hA; mlp_cycle_cnt = 5'h13;
    tab.push_back(mkvec(8'h01, 8'hA5, 8'h00, 2, mkexp(1,0,0,0,0,0,0,64'h0), 0, 8'hA5, 16'h0000));
    tab.push_back(mkvec(8'h02, 8'h3C, 8'h00, 2, mkexp(0,1,0,0,0,0,0,64'h0), 0, 8'h3C, 16'h0000));
    tab.push_back(mkvec(8'h03, 8'h34, 8'h12, 3, mkexp(0,0,1,0,0,0,0,64'h0), 0, 8'h3C, 16'h1234));
    tab.push_back(mkvec(8'h06, 8'h00, 8'h00, 1, mkexp(0,0,0,0,0,1,0,64'h0), 0, 8'h3C, 16'h1234));
    tab.push_back(mkvec(8'h05, 8'h00, 8'h00, 1, mkexp(0,0,0,0,0,0,0,64'h0), 1, 8'h3C, 16'h1234));
    tab.push_back(mkvec(8'h06, 8'h00, 8'h00, 1, mkexp(0,0,0,0,1,0,0,64'h0), 1, 8'h3C, 16'h1234));
    tab.push_back(mkvec(8'h04, 8'h00, 8'h00, 1, mkexp(0,0,0,1,0,0,0,64'h0), 0, 8'h3C, 16'h1234));
    tab.push_back(mkvec(8'h07, 8'h00, 8'h00, 1, mkexp(0,0,0,0,0,0,2,64'h130A), 0, 8'h3C, 16'h1234));
    tab.push_back(mkvec(8'h99, 8'h00, 8'h00, 1, mkexp(0,0,0,0,0,1,1,64'hEE), 0, 8'h3C, 16'h1234));
    tab.push_back(mkvec(8'h00, 8'h00, 8'h00, 1, mkexp(0,0,0,0,0,1,1,64'hEE), 0, 8'h3C, 16'h1234));
    tab.push_back(mkvec(8'h09, 8'h00, 8'h00, 1, mkexp(0,0,0,0,0,1,1,64'hEE), 0, 8'h3C, 16'h1234));
    for (int i = 0; i < tab.size(); i++) begin
      clear_cap();
      send_cmd(tab[i].op, tab[i].a1, tab[i].a2, tab[i].nb, 0);
      wait_quiet();
      check_cmd($sformatf("tab%0d_op%02h", i, tab[i].op), tab[i].e, tab[i].ready,
                tab[i].wf, tab[i].act);
    end
    m_ready = 1'b0; m_wf = 8'h3C; m_act = 16'h1234;

    // ---- READ_ACC with stalling consumer and snapshot check ----
    rdy_rand = 1'b1;
    mlp_acc0 = 32'sh11223344; mlp_acc1 = -32'sd1;
    clear_cap();
    send_byte(8'h08);
    mlp_acc0 = 32'sh0BADF00D; mlp_acc1 = 32'sh5555;
    wait_quiet();
    check_cmd("read_acc", mkexp(0,0,0,0,0,0,8,64'hFFFFFFFF_11223344), m_ready, m_wf, m_act);

    // ---- back-to-back commands, minimum spacing ----
    clear_cap();
    send_byte(8'h01); send_byte(8'h5A); send_byte(8'h02); send_byte(8'hC3);
    wait_quiet();
    m_wf = 8'hC3;
    check_cmd("back2back", mkexp(1,1,0,0,0,0,0,64'h0), m_ready, m_wf, m_act);

    // ---- argument timeout boundary ----
    clear_cap();
    send_byte(8'h02); idle(TMO - 1); send_byte(8'h77);
    wait_quiet();
    m_wf = 8'h77;
    check_cmd("tmo_edge_ok", mkexp(0,1,0,0,0,0,0,64'h0), m_ready, m_wf, m_act);

    clear_cap();
    send_byte(8'h02); idle(TMO + 4);
    check_cmd("tmo_abort_w", mkexp(0,0,0,0,0,1,0,64'h0), m_ready, m_wf, m_act);
    mlp_state = 4'h5; mlp_cycle_cnt = 5'h1F;
    clear_cap();
    send_byte(8'h07);
    wait_quiet();
    check_cmd("status_after_tmo", mkexp(0,0,0,0,0,0,2,64'h1F05), m_ready, m_wf, m_act);

    clear_cap();
    send_byte(8'h03); send_byte(8'h11); idle(TMO + 2);
    check_cmd("tmo_abort_act", mkexp(0,0,0,0,0,1,0,64'h0), m_ready, m_wf, m_act);

    // ---- byte arriving during a response is dropped ----
    rdy_rand = 1'b0; rdy_fixed = 1'b0;
    mlp_state = 4'h3; mlp_cycle_cnt = 5'h04;
    clear_cap();
    send_byte(8'h07); idle(2); send_byte(8'h05); idle(2);
    rdy_fixed = 1'b1;
    wait_quiet();
    check_cmd("rx_in_tx", mkexp(0,0,0,0,0,1,2,64'h0403), m_ready, m_wf, m_act);

    // ---- reset in the middle of READ_ACC ----
    send_byte(8'h05); idle(2);
    rdy_fixed = 1'b0;
    clear_cap();
    send_byte(8'h08); idle(3);
    check("stall_tx_valid", 64'(tx_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", {tx_valid, push0, push1, wf_data, wf_reset, act_valid,
                             act_data, start_mlp, wready, cmd_err}, 64'h0);
    rst = 1'b0;
    m_ready = 1'b0; m_wf = 8'h00; m_act = 16'h0000;
    rdy_fixed = 1'b1;
    idle(1);
    clear_cap();
    send_byte(8'h07);
    wait_quiet();
    check_cmd("status_after_rst", mkexp(0,0,0,0,0,0,2,64'h0403), m_ready, m_wf, m_act);

    // ---- randomized commands against the model ----
    rdy_rand = 1'b1;
    for (int k = 0; k < 150; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 8)       op = 8'(r + 1);
      else if (r == 8) op = 8'h00;
      else             op = 8'(9 + $urandom_range(0, 246));
      a1 = 8'($urandom); a2 = 8'($urandom);
      mlp_state = 4'($urandom); mlp_cycle_cnt = 5'($urandom);
      mlp_acc0 = 32'($urandom); mlp_acc1 = 32'($urandom);
      model_cmd(op, a1, a2, e, nb);
      clear_cap();
      send_cmd(op, a1, a2, nb, int'($urandom_range(0, TMO - 1)));
      mlp_state = 4'($urandom); mlp_acc0 = 32'($urandom); mlp_acc1 = 32'($urandom);
      wait_quiet();
      check_cmd($sformatf("rnd%0d_op%02h", k, op), e, m_ready, m_wf, m_act);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
